// File: rtl/startup_pattern_engine_pkg.sv
// Shared defaults, widths and transfer FSM encodings for the startup pattern engine.
package startup_disp_pkg;

    localparam int unsigned NPAT_DEF     = 16;
    localparam int unsigned PAT_W_DEF    = 16;
    localparam int unsigned SCLK_DIV_DEF = 2;
    localparam int unsigned TMR_W        = 16;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_SHIFT_LO = 2'd1;
    localparam logic [1:0] ST_SHIFT_HI = 2'd2;
    localparam logic [1:0] ST_STROBE   = 2'd3;

endpackage

// File: rtl/startup_pattern_engine_if.sv
// Control inputs and display/status outputs of the startup pattern engine.
interface startup_pattern_engine_if;

    logic                               CLEAR;
    logic                               DISP;
    logic                               LOAD_PAT;
    logic                               NXT_ADR;
    logic                               RST_TMR;
    logic [startup_disp_pkg::TMR_W-1:0] TMR;
    logic                               DONE;
    logic                               SCLK;
    logic                               SDATA;
    logic                               LATCH;
    logic                               BLANK;
    logic                               BUSY;

    modport master (
        output CLEAR, DISP, LOAD_PAT, NXT_ADR, RST_TMR,
        input  TMR, DONE, SCLK, SDATA, LATCH, BLANK, BUSY
    );

    modport slave (
        input  CLEAR, DISP, LOAD_PAT, NXT_ADR, RST_TMR,
        output TMR, DONE, SCLK, SDATA, LATCH, BLANK, BUSY
    );

endinterface

// File: rtl/startup_pattern_rom.sv
// Walking-one pattern ROM; any address at or past NPAT reads as all zeros.
module startup_pattern_rom #(
    parameter int unsigned NPAT  = startup_disp_pkg::NPAT_DEF,
    parameter int unsigned PAT_W = startup_disp_pkg::PAT_W_DEF,
    parameter int unsigned ADR_W = $clog2(NPAT + 1)
) (
    input  logic [ADR_W-1:0] adr,
    output logic [PAT_W-1:0] pat
);

    always_comb begin
        pat = '0;
        if (32'(adr) < NPAT) begin
            pat = PAT_W'(1) << (32'(adr) % PAT_W);
        end
    end

endmodule

// File: rtl/startup_pattern_engine.sv
// Startup pattern sequencer: dwell timer, pattern address, serial display shifter.
// Define STARTUP_PAT_CHKSUM_EN to add the CHKSUM port and its XOR accumulator.
module startup_pattern_engine
    import startup_disp_pkg::*;
#(
    parameter int unsigned NPAT     = NPAT_DEF,
    parameter int unsigned PAT_W    = PAT_W_DEF,
    parameter int unsigned SCLK_DIV = SCLK_DIV_DEF
) (
    input  logic                       CLK,
    input  logic                       RST,
    startup_pattern_engine_if.slave    bus
`ifdef STARTUP_PAT_CHKSUM_EN
    ,
    output logic [PAT_W-1:0]           CHKSUM
`endif
);

    localparam int unsigned ADR_W = $clog2(NPAT + 1);
    localparam int unsigned BIT_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam int unsigned DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

    logic [1:0]       state, state_nx;
    logic [PAT_W-1:0] pat, pat_nx, rom_pat;
    logic [BIT_W-1:0] bit_cnt, bit_cnt_nx;
    logic [DIV_W-1:0] div_cnt, div_cnt_nx;
    logic [ADR_W-1:0] adr, adr_nx;
    logic [TMR_W-1:0] tmr, tmr_nx;
    logic             done, sclk, sdata, latch, busy, blank;
    logic             phase_end_c;

    startup_pattern_rom #(
        .NPAT  (NPAT),
        .PAT_W (PAT_W),
        .ADR_W (ADR_W)
    ) u_rom (
        .adr (adr),
        .pat (rom_pat)
    );

    assign phase_end_c = (div_cnt == DIV_W'(SCLK_DIV - 1));

    // Transfer next-state; CLEAR overrides everything including a pending load.
    always_comb begin
        state_nx   = state;
        pat_nx     = pat;
        bit_cnt_nx = bit_cnt;
        div_cnt_nx = div_cnt;
        if (bus.CLEAR) begin
            state_nx   = ST_IDLE;
            pat_nx     = '0;
            bit_cnt_nx = '0;
            div_cnt_nx = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.LOAD_PAT) begin
                        pat_nx     = rom_pat;
                        bit_cnt_nx = BIT_W'(PAT_W - 1);
                        div_cnt_nx = '0;
                        state_nx   = ST_SHIFT_LO;
                    end
                end
                ST_SHIFT_LO: begin
                    if (phase_end_c) begin
                        div_cnt_nx = '0;
                        state_nx   = ST_SHIFT_HI;
                    end else begin
                        div_cnt_nx = div_cnt + DIV_W'(1);
                    end
                end
                ST_SHIFT_HI: begin
                    if (phase_end_c) begin
                        div_cnt_nx = '0;
                        if (bit_cnt == '0) begin
                            state_nx = ST_STROBE;
                        end else begin
                            bit_cnt_nx = bit_cnt - BIT_W'(1);
                            state_nx   = ST_SHIFT_LO;
                        end
                    end else begin
                        div_cnt_nx = div_cnt + DIV_W'(1);
                    end
                end
                ST_STROBE: state_nx = ST_IDLE;
                default:   state_nx = ST_IDLE;
            endcase
        end
    end

    // Address saturates at NPAT; timer saturates at all-ones.
    always_comb begin
        adr_nx = adr;
        if (bus.NXT_ADR && (adr != ADR_W'(NPAT))) begin
            adr_nx = adr + ADR_W'(1);
        end
        tmr_nx = tmr;
        if (bus.RST_TMR) begin
            tmr_nx = '0;
        end else if (tmr != '1) begin
            tmr_nx = tmr + TMR_W'(1);
        end
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= ST_IDLE;
            pat     <= '0;
            bit_cnt <= '0;
            div_cnt <= '0;
            adr     <= '0;
            tmr     <= '0;
            done    <= 1'b0;
            sclk    <= 1'b0;
            sdata   <= 1'b0;
            latch   <= 1'b0;
            busy    <= 1'b0;
            blank   <= 1'b1;
        end else begin
            state   <= state_nx;
            pat     <= pat_nx;
            bit_cnt <= bit_cnt_nx;
            div_cnt <= div_cnt_nx;
            adr     <= adr_nx;
            tmr     <= tmr_nx;
            done    <= (adr_nx == ADR_W'(NPAT));
            sclk    <= (state_nx == ST_SHIFT_HI);
            sdata   <= ((state_nx == ST_SHIFT_LO) || (state_nx == ST_SHIFT_HI)) ?
                       pat_nx[bit_cnt_nx] : 1'b0;
            latch   <= (state_nx == ST_STROBE);
            busy    <= (state_nx != ST_IDLE);
            blank   <= ~bus.DISP;
        end
    end

    assign bus.TMR   = tmr;
    assign bus.DONE  = done;
    assign bus.SCLK  = sclk;
    assign bus.SDATA = sdata;
    assign bus.LATCH = latch;
    assign bus.BLANK = blank;
    assign bus.BUSY  = busy;

`ifdef STARTUP_PAT_CHKSUM_EN
    logic             load_ok_c;
    logic [PAT_W-1:0] chksum;

    assign load_ok_c = (state == ST_IDLE) && bus.LOAD_PAT && !bus.CLEAR;

    // Accumulates every accepted pattern; only RST clears it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            chksum <= '0;
        end else if (load_ok_c) begin
            chksum <= chksum ^ rom_pat;
        end
    end

    assign CHKSUM = chksum;
`endif

endmodule

// File: tb/tb_startup_pattern_engine.sv
// Scoreboard bench for startup_pattern_engine: expected transfers are queued by the
// stimulus and checked by an independent serial-line monitor.
module tb_startup_pattern_engine;
    import startup_disp_pkg::*;

    localparam int unsigned NPAT     = 16;
    localparam int unsigned PAT_W    = 16;
    localparam int unsigned SCLK_DIV = 2;
    localparam int          XFER_LEN = 2 * SCLK_DIV * PAT_W + 1;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    startup_pattern_engine_if bus();
`ifdef STARTUP_PAT_CHKSUM_EN
    logic [PAT_W-1:0] CHKSUM;
`endif

    startup_pattern_engine #(
        .NPAT     (NPAT),
        .PAT_W    (PAT_W),
        .SCLK_DIV (SCLK_DIV)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
`ifdef STARTUP_PAT_CHKSUM_EN
        ,
        .CHKSUM (CHKSUM)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [PAT_W-1:0] pat;
        bit               aborted;
    } exp_t;

    exp_t             exp_q[$];
    int               checks = 0;
    int               errors = 0;
    int               model_adr = 0;
    logic [PAT_W-1:0] model_chk = '0;

    // Reference rule: walking one per address, zeros once past the last pattern.
    function automatic logic [PAT_W-1:0] ref_pat(int a);
        if (a >= int'(NPAT)) return '0;
        return PAT_W'(1) << (a % int'(PAT_W));
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.BUSY !== 1'b0 && n < 500) begin
            tick();
            n++;
        end
        check("wait_idle_timeout", 32'(n >= 500), 32'd0);
    endtask

    task automatic do_load(bit with_nxt);
        exp_t e;
        bus.LOAD_PAT = 1'b1;
        bus.NXT_ADR  = with_nxt;
        e.pat        = ref_pat(model_adr);
        e.aborted    = 1'b0;
        exp_q.push_back(e);
        model_chk    = model_chk ^ ref_pat(model_adr);
        if (with_nxt && model_adr < int'(NPAT)) model_adr++;
        tick();
        bus.LOAD_PAT = 1'b0;
        bus.NXT_ADR  = 1'b0;
        check("busy_after_load", 32'(bus.BUSY), 32'd1);
    endtask

    task automatic nxt_pulse();
        bus.NXT_ADR = 1'b1;
        if (model_adr < int'(NPAT)) model_adr++;
        tick();
        bus.NXT_ADR = 1'b0;
        check("done", 32'(bus.DONE), 32'(model_adr == int'(NPAT)));
    endtask

    task automatic mark_abort();
        if (exp_q.size() > 0) exp_q[exp_q.size() - 1].aborted = 1'b1;
    endtask

    // Monitor: rebuilds each transfer from SCLK rising edges and retires it on LATCH or abort.
    bit               in_xfer = 1'b0;
    bit               latched = 1'b0;
    bit               prev_sclk = 1'b0;
    int               busy_cnt = 0;
    int               nbits = 0;
    logic [PAT_W-1:0] bits = '0;
    exp_t             got_e;

    task automatic retire_abort();
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_abort: transfer ended with no queued entry at %0t", $time);
        end else begin
            got_e = exp_q.pop_front();
            check("abort_expected", 32'(got_e.aborted), 32'd1);
        end
    endtask

    always @(negedge CLK) begin
        if (RST) begin
            if (in_xfer) begin
                in_xfer = 1'b0;
                if (!latched) retire_abort();
            end
        end else if (bus.BUSY) begin
            if (!in_xfer) begin
                in_xfer   = 1'b1;
                latched   = 1'b0;
                prev_sclk = 1'b0;
                busy_cnt  = 0;
                nbits     = 0;
                bits      = '0;
            end
            busy_cnt++;
            if (bus.SCLK && !prev_sclk) begin
                bits = {bits[PAT_W-2:0], bus.SDATA};
                nbits++;
            end
            prev_sclk = bus.SCLK;
            if (bus.LATCH) begin
                latched = 1'b1;
                check("latch_cycle", 32'(busy_cnt), 32'(XFER_LEN));
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_latch: LATCH with no queued entry at %0t", $time);
                end else begin
                    got_e = exp_q.pop_front();
                    check("latch_not_aborted", 32'(got_e.aborted), 32'd0);
                    check("pattern", 32'(bits), 32'(got_e.pat));
                    check("bit_count", 32'(nbits), 32'(PAT_W));
                end
            end
        end else if (in_xfer) begin
            in_xfer = 1'b0;
            check("latch_low_when_idle", 32'(bus.LATCH), 32'd0);
            if (latched) check("busy_len", 32'(busy_cnt), 32'(XFER_LEN));
            else retire_abort();
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int npulse;
        bus.CLEAR    = 1'b0;
        bus.DISP     = 1'b0;
        bus.LOAD_PAT = 1'b0;
        bus.NXT_ADR  = 1'b0;
        bus.RST_TMR  = 1'b0;
        repeat (2) tick();

        check("rst_tmr",   32'(bus.TMR),   32'd0);
        check("rst_done",  32'(bus.DONE),  32'd0);
        check("rst_sclk",  32'(bus.SCLK),  32'd0);
        check("rst_sdata", 32'(bus.SDATA), 32'd0);
        check("rst_latch", 32'(bus.LATCH), 32'd0);
        check("rst_busy",  32'(bus.BUSY),  32'd0);
        check("rst_blank", 32'(bus.BLANK), 32'd1);
`ifdef STARTUP_PAT_CHKSUM_EN
        check("rst_chksum", 32'(CHKSUM), 32'd0);
`endif
        RST = 1'b0;

        // Dwell timer counts one per clock from reset release.
        repeat (3000) tick();
        check("tmr_3000", 32'(bus.TMR), 32'h0BB8);
        bus.RST_TMR = 1'b1;
        tick();
        check("tmr_cleared", 32'(bus.TMR), 32'd0);
        bus.RST_TMR = 1'b0;
        tick();
        check("tmr_restart", 32'(bus.TMR), 32'd1);

        check("blank_disp0", 32'(bus.BLANK), 32'd1);
        bus.DISP = 1'b1;
        tick();
        check("blank_disp1", 32'(bus.BLANK), 32'd0);
        bus.DISP = 1'b0;
        check("blank_latency", 32'(bus.BLANK), 32'd0);
        tick();
        check("blank_after_fall", 32'(bus.BLANK), 32'd1);
        bus.DISP = 1'b1;
        tick();

        // Loads at addresses 0..2, each with extra LOAD_PAT pulses while busy.
        for (int a = 0; a < 3; a++) begin
            do_load(1'b0);
            repeat (3) begin
                bus.LOAD_PAT = 1'b1;
                tick();
            end
            bus.LOAD_PAT = 1'b0;
            wait_idle();
            tick();
            nxt_pulse();
        end
`ifdef STARTUP_PAT_CHKSUM_EN
        check("chksum_012", 32'(CHKSUM), 32'(model_chk));
        check("chksum_012_value", 32'(model_chk), 32'h0007);
`endif

        check("model_adr_3", 32'(ref_pat(model_adr)), 32'h0008);
        do_load(1'b0);
        wait_idle();
        tick();

        // Randomized address steps and loads, some with NXT_ADR in the same cycle.
        repeat (8) begin
            npulse = (model_adr < 10) ? int'($urandom_range(0, 2)) : 0;
            repeat (npulse) nxt_pulse();
            repeat ($urandom_range(0, 3)) tick();
            do_load((model_adr < 11) ? 1'($urandom_range(0, 1)) : 1'b0);
            repeat ($urandom_range(0, 2)) begin
                bus.LOAD_PAT = 1'b1;
                tick();
            end
            bus.LOAD_PAT = 1'b0;
            wait_idle();
            tick();
        end

        // CLEAR while shifting bit 7 aborts without LATCH.
        do_load(1'b0);
        repeat ((PAT_W - 1 - 7) * 2 * SCLK_DIV) tick();
        mark_abort();
        bus.CLEAR    = 1'b1;
        bus.LOAD_PAT = 1'b1;
        tick();
        bus.LOAD_PAT = 1'b0;
        bus.CLEAR    = 1'b0;
        check("clear_busy",  32'(bus.BUSY),  32'd0);
        check("clear_sclk",  32'(bus.SCLK),  32'd0);
        check("clear_sdata", 32'(bus.SDATA), 32'd0);
        check("clear_latch", 32'(bus.LATCH), 32'd0);
        tick();
        check("clear_latch_next", 32'(bus.LATCH), 32'd0);
        bus.CLEAR    = 1'b1;
        bus.LOAD_PAT = 1'b1;
        tick();
        bus.CLEAR    = 1'b0;
        bus.LOAD_PAT = 1'b0;
        check("clear_beats_load", 32'(bus.BUSY), 32'd0);
        tick();
        do_load(1'b0);
        wait_idle();
        tick();

        // Walk the address to the end, then one extra pulse must not move it.
        while (model_adr < int'(NPAT)) nxt_pulse();
        nxt_pulse();
        do_load(1'b0);
        wait_idle();
        tick();
        nxt_pulse();

        // Reset in the middle of a shift.
        npulse = 0;
        RST = 1'b1;
        #1;
        RST = 1'b0;
        model_adr = 0;
        model_chk = '0;
        tick();
        do_load(1'b0);
        repeat (10) tick();
        mark_abort();
        RST = 1'b1;
        #1;
        check("rstmid_busy",  32'(bus.BUSY),  32'd0);
        check("rstmid_sclk",  32'(bus.SCLK),  32'd0);
        check("rstmid_sdata", 32'(bus.SDATA), 32'd0);
        check("rstmid_latch", 32'(bus.LATCH), 32'd0);
        check("rstmid_blank", 32'(bus.BLANK), 32'd1);
        check("rstmid_tmr",   32'(bus.TMR),   32'd0);
        check("rstmid_done",  32'(bus.DONE),  32'd0);
        tick();
        RST = 1'b0;
        model_adr = 0;
        model_chk = '0;
        tick();
`ifdef STARTUP_PAT_CHKSUM_EN
        check("rstmid_chksum", 32'(CHKSUM), 32'd0);
`endif
        do_load(1'b1);
        wait_idle();
        tick();
        do_load(1'b0);
        wait_idle();
        repeat (3) tick();
`ifdef STARTUP_PAT_CHKSUM_EN
        check("final_chksum", 32'(CHKSUM), 32'(model_chk));
`endif
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/startup_pattern_engine.md
STARTUP_PATTERN_ENGINE -- requirements
Module: startup_pattern_engine

Interface
REQ-001 Parameter NPAT, 16, number of startup patterns (2..256).
REQ-002 Parameter PAT_W, 16, pattern width in bits.
REQ-003 Parameter SCLK_DIV, 2, CLK cycles per SCLK half-period (>=1).
REQ-004 CLK  input  1  system clock; all logic on rising edge.
REQ-005 RST  input  1  reset, asynchronous, active-high.
REQ-006 CLEAR  input  1  abort shift, zero pattern register.
REQ-007 DISP  input  1  display enable; 0 blanks display.
REQ-008 LOAD_PAT  input  1  fetch ROM[adr] and start serial transfer.
REQ-009 NXT_ADR  input  1  advance pattern address.
REQ-010 RST_TMR  input  1  hold dwell timer at zero.
REQ-011 TMR  output  16  dwell timer value.
REQ-012 DONE  output  1  address has passed last pattern.
REQ-013 SCLK  output  1  display serial clock.
REQ-014 SDATA  output  1  display serial data, MSB first.
REQ-015 LATCH  output  1  one-cycle strobe after last bit.
REQ-016 BLANK  output  1  display blank, registered.
REQ-017 BUSY  output  1  serial transfer in progress.

Function
REQ-018 Timer SHALL be 0 in any cycle after RST_TMR=1 sampled, else increment by 1 per CLK, saturating at 16'hFFFF.
REQ-019 Address adr SHALL be ceil(log2(NPAT+1)) bits, 0 after reset, increment on NXT_ADR, saturating at NPAT.
REQ-020 DONE SHALL equal (adr == NPAT) from registered adr, valid the cycle after the incrementing NXT_ADR.
REQ-021 ROM SHALL hold ROM[i] = 1 << (i mod PAT_W) (walking one).
REQ-022 Transfer FSM states IDLE, SHIFT_LO, SHIFT_HI, STROBE.
REQ-023 IDLE: LOAD_PAT=1 -> pattern register <= ROM[adr] (all zeros if adr==NPAT), bit counter <= PAT_W-1, BUSY=1 next cycle, go SHIFT_LO.
REQ-024 SHIFT_LO: SCLK=0, SDATA=current bit, held SCLK_DIV cycles, then SHIFT_HI.
REQ-025 SHIFT_HI: SCLK=1 SCLK_DIV cycles; bit counter 0 -> STROBE, else decrement, back to SHIFT_LO.
REQ-026 STROBE: LATCH=1 exactly one cycle, then IDLE, BUSY=0 that next cycle.
REQ-027 Transfer length SHALL be 2*SCLK_DIV*PAT_W + 1 cycles from first BUSY cycle to last.
REQ-028 LOAD_PAT while BUSY=1 SHALL be ignored.
REQ-029 LOAD_PAT and NXT_ADR same cycle: load uses pre-increment adr.
REQ-030 CLEAR SHALL take priority over LOAD_PAT: next cycle FSM IDLE, pattern 0, SCLK=0, SDATA=0, BUSY=0, no LATCH; adr unaffected.
REQ-031 BLANK SHALL equal registered ~DISP, one cycle latency.

Reset
REQ-032 RST SHALL force: FSM IDLE, adr 0, TMR 0, DONE 0, SCLK 0, SDATA 0, LATCH 0, BUSY 0, BLANK 1, pattern 0.
REQ-033 RST mid-transfer SHALL abort immediately without LATCH.

Configuration
REQ-034 Macro STARTUP_PAT_CHKSUM_EN defined: extra output CHKSUM[PAT_W-1:0], reset 0, XOR-accumulates each accepted (non-ignored) loaded pattern, cleared only by RST.
REQ-035 Macro undefined: no CHKSUM port, no accumulator logic.

Structure
REQ-036 Package startup_disp_pkg SHALL hold NPAT/PAT_W defaults, TMR_W=16, and transfer FSM state encodings.
REQ-037 ROM SHALL be sub-module startup_pattern_rom (adr in, pattern out, combinational).

Verification
REQ-038 RST_TMR=0 for 3000 cycles after reset -> TMR==16'h0BB8; RST_TMR=1 one cycle -> TMR==0.
REQ-039 LOAD_PAT at adr=3, SCLK_DIV=2 -> SDATA bits 16'h0008 MSB first on SCLK rising edges, LATCH at 65th BUSY cycle, BUSY low after.
REQ-040 16 NXT_ADR pulses -> DONE=1 after 16th, adr stays 16 on 17th; LOAD_PAT then shifts 16'h0000.
REQ-041 CLEAR at bit 7 of transfer -> BUSY=0, SCLK=0 next cycle, no LATCH; following LOAD_PAT transfers normally.
REQ-042 LOAD_PAT repeated mid-transfer -> ignored, one LATCH only; with STARTUP_PAT_CHKSUM_EN, loads at adr 0,1,2 -> CHKSUM==16'h0007.
REQ-043 DISP 1->0 -> BLANK 0->1 one cycle later; RST mid-shift -> all outputs reset values, BLANK=1.
